matrix_scratchpad: RTL and testbench
====================================

# matrix_scratchpad

Word-addressed scratchpad memory that services the matrix multiplication engine's memory request port and a host load/unload port. The host preloads the parameter words (addresses 0–3) and operand matrices before the engine is enabled, then reads back the result matrix. The block sits directly downstream of the engine and answers its `mem_operation`/`addr_o`/`data_o` requests with `mem_opdone` and read data. The two ports are arbitrated round-robin onto a single-ported array.

## Interface
- `DATA_W`, 32, word width; must equal the engine's data width.
- `ADDR_W`, 8, array index width; DEPTH = 2**ADDR_W words.
- `WAIT_STATES`, 1, extra cycles per access; legal range 0–15.

- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `acc_mem_operation`  in  2  engine request: 01 read, 11 write, 00 none, 10 reserved (treated as none).
- `acc_addr`  in  32  engine word address.
- `acc_wdata`  in  DATA_W  engine write data.
- `acc_rdata`  out  DATA_W  read data to engine.
- `acc_opdone`  out  1  one-cycle completion pulse to engine.
- `host_req`  in  1  host request; held high until `host_ack`.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  ADDR_W  host word address.
- `host_wdata`  in  DATA_W  host write data.
- `host_rdata`  out  DATA_W  read data to host.
- `host_ack`  out  1  one-cycle completion pulse to host.
- `err`  out  1  sticky; engine accessed an address ≥ DEPTH.

## Operation
- **Storage.** DEPTH×DATA_W register array. The array is not reset; its contents survive `reset`.
- **States.**
  - IDLE: arbitrate pending requests.
  - WAIT: count down the wait states.
  - RESP: perform the access and pulse done.
  - Reset state is IDLE.
- **Arbitration in IDLE.** An engine request is pending when `acc_mem_operation` is 01 or 11. A host request is pending when `host_req` is 1.
  - Only one pending: grant it.
  - Both pending: grant the port not granted last. The last-grant flag resets to "host", so the engine wins the first tie.
- **Grant edge.** Latch port, op, address and write data. Load the wait counter with `WAIT_STATES`. Go to WAIT.
- **WAIT.** If the counter is 0, go to RESP; otherwise decrement it. Requester inputs are ignored while in WAIT.
- **RESP edge (entry into RESP).**
  - Write: commit the latched data to the array.
  - Read: load `acc_rdata` or `host_rdata` from the array.
  - Assert the granted port's done output (`acc_opdone` or `host_ack`) for exactly that one cycle.
- **After RESP.** Always return to IDLE. The request lines are re-sampled in IDLE on the next edge, so a requester that updates its address or op on the done edge is served as a new transaction.
- **Engine address range.** If `acc_addr[31:ADDR_W]` ≠ 0:
  - a read returns 0;
  - a write is dropped;
  - `acc_opdone` still pulses;
  - `err` is set at the RESP edge.
- **Host address range.** `host_addr` is always in range.
- **Read data hold.** `acc_rdata` and `host_rdata` keep their value until the next read on the same port completes.
- **Reset mid-operation.** Any in-flight access is abandoned and the state returns to IDLE. A write not yet at its RESP edge is not committed.

## Timing
- **Reset values.**
  - `acc_rdata` = 0, `host_rdata` = 0.
  - `acc_opdone` = 0, `host_ack` = 0, `err` = 0.
  - Wait counter = 0; last-grant flag = host.
- **Latency.** With the grant at edge E, done rises at edge E + WAIT_STATES + 1 and falls one edge later.
- **Throughput.** One access per WAIT_STATES + 3 cycles (grant, wait, resp, idle).
- **Back-to-back on one port.** Earliest next grant to the same port is the edge after done falls.
- **Simultaneous new requests.** An engine and a host request arriving in the same IDLE cycle are resolved by the last-grant rule. The losing request waits; it is guaranteed service within one transaction.

## Test plan
- **Host preload and readback.** `WAIT_STATES`=1. Host writes 2,2,2,2 to addresses 0–3 and 1..8 to addresses 4–11, then reads address 5. Required: `host_ack` rises 2 edges after each grant; `host_rdata` = 2.
- **Engine read sequence.** Engine holds op=01 and steps addr 0,1,2,3 on each `acc_opdone`. Required: four `acc_opdone` pulses; `acc_rdata` = 2,2,2,2; each address served exactly once; no duplicate pulse.
- **Engine write then host read.** Engine writes 0x13 to address 12 with op=11 and drops op to 00 on done. Then host reads address 12. Required: exactly one write; `host_rdata` = 0x13.
- **Contention.** Engine and host both request in the same cycle, twice in a row. Required grant order: engine, host, engine. No request is lost.
- **Out of range.** Engine reads address 0x100 (`ADDR_W`=8). Required: `acc_opdone` pulses, `acc_rdata` = 0, `err` = 1 and stays 1. A subsequent write to 0x1FF does not modify address 0xFF.
- **Reset mid-write.** Host writes 0xAA to address 7 with `WAIT_STATES`=3; assert `reset` during WAIT. Required: no `host_ack`; address 7 keeps its old value; all outputs take their reset values on the next edge.

Source files
------------

// File: rtl/matrix_scratchpad.sv
// matrix_scratchpad
// Word-addressed single-ported scratchpad shared by the matrix engine's memory
// request port and a host load/unload port. Requests from the two ports are
// arbitrated round-robin in IDLE. Each access then spends WAIT_STATES cycles in
// WAIT and completes on entry into RESP.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   acc_mem_operation  engine op: 01 read, 11 write, 00/10 none
//   acc_addr           engine word address (bits above ADDR_W must be zero)
//   acc_wdata          engine write data
//   acc_rdata          engine read data, held until the next engine read
//   acc_opdone         one-cycle engine completion pulse
//   host_req           host request, held until host_ack
//   host_we            host write (1) / read (0)
//   host_addr          host word address
//   host_wdata         host write data
//   host_rdata         host read data, held until the next host read
//   host_ack           one-cycle host completion pulse
//   err                sticky flag: engine used an address >= DEPTH
//
// state  | meaning
// IDLE   | arbitrate pending requests, latch the winner
// WAIT   | count down wait states; access happens on the exit edge
// RESP   | done pulse is high; always returns to IDLE
module matrix_scratchpad #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        acc_mem_operation,
    input  logic [31:0]       acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              acc_opdone,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              err
);
    localparam int         DEPTH     = 2**ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_host_q, last_host_d;
    logic              port_host_q, port_host_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] acc_rdata_q, acc_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              acc_opdone_q, acc_opdone_d;
    logic              host_ack_q, host_ack_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;

    logic              acc_pend;
    logic              grant_host;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;

    // Opcode 10 is reserved and behaves like no request.
    assign acc_pend   = (acc_mem_operation == 2'b01) || (acc_mem_operation == 2'b11);
    // On a tie the host wins only if the engine was granted last.
    assign grant_host = host_req && (!acc_pend || !last_host_q);
    // Host addresses cannot leave the array; engine upper bits must be zero.
    assign in_range   = port_host_q || (addr_q[31:ADDR_W] == '0);
    assign rd_word    = in_range ? mem_q[addr_q[ADDR_W-1:0]] : '0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_host_d  = last_host_q;
        port_host_d  = port_host_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        acc_rdata_d  = acc_rdata_q;
        host_rdata_d = host_rdata_q;
        acc_opdone_d = 1'b0;
        host_ack_d   = 1'b0;
        err_d        = err_q;
        mem_we       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (acc_pend || host_req) begin
                    state_d     = S_WAIT;
                    cnt_d       = WAIT_INIT;
                    port_host_d = grant_host;
                    last_host_d = grant_host;
                    if (grant_host) begin
                        we_d    = host_we;
                        addr_d  = 32'(host_addr);
                        wdata_d = host_wdata;
                    end else begin
                        we_d    = acc_mem_operation[1];
                        addr_d  = acc_addr;
                        wdata_d = acc_wdata;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    if (we_q) begin
                        // Gated so a reset on this very edge abandons the write.
                        mem_we = in_range && !reset;
                    end else if (port_host_q) begin
                        host_rdata_d = rd_word;
                    end else begin
                        acc_rdata_d = rd_word;
                    end
                    if (port_host_q) begin
                        host_ack_d = 1'b1;
                    end else begin
                        acc_opdone_d = 1'b1;
                        if (!in_range) begin
                            err_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            last_host_q  <= 1'b1;
            port_host_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            acc_rdata_q  <= '0;
            host_rdata_q <= '0;
            acc_opdone_q <= 1'b0;
            host_ack_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_host_q  <= last_host_d;
            port_host_q  <= port_host_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            acc_rdata_q  <= acc_rdata_d;
            host_rdata_q <= host_rdata_d;
            acc_opdone_q <= acc_opdone_d;
            host_ack_q   <= host_ack_d;
            err_q        <= err_d;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q[ADDR_W-1:0]] <= wdata_q;
        end
    end

    assign acc_rdata  = acc_rdata_q;
    assign host_rdata = host_rdata_q;
    assign acc_opdone = acc_opdone_q;
    assign host_ack   = host_ack_q;
    assign err        = err_q;
endmodule

// File: tb/tb_matrix_scratchpad.sv
module tb_matrix_scratchpad;
    // Instance 0 runs with one wait state, instance 1 with three.
    logic        clk;
    logic        reset      [2];
    logic [1:0]  acc_op     [2];
    logic [31:0] acc_addr   [2];
    logic [31:0] acc_wdata  [2];
    logic [31:0] acc_rdata  [2];
    logic        acc_opdone [2];
    logic        host_req   [2];
    logic        host_we    [2];
    logic [7:0]  host_addr  [2];
    logic [31:0] host_wdata [2];
    logic [31:0] host_rdata [2];
    logic        host_ack   [2];
    logic        err        [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain word array plus a sticky error flag.
    logic [31:0] ref_mem   [256];
    bit          ref_valid [256];
    bit          ref_err;

    typedef struct {
        bit          host;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          chk;
    } vec_t;
    vec_t vecs [20];

    matrix_scratchpad #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(1)) u_dut0 (
        .clk(clk), .reset(reset[0]),
        .acc_mem_operation(acc_op[0]), .acc_addr(acc_addr[0]), .acc_wdata(acc_wdata[0]),
        .acc_rdata(acc_rdata[0]), .acc_opdone(acc_opdone[0]),
        .host_req(host_req[0]), .host_we(host_we[0]), .host_addr(host_addr[0]),
        .host_wdata(host_wdata[0]), .host_rdata(host_rdata[0]), .host_ack(host_ack[0]),
        .err(err[0]));

    matrix_scratchpad #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset(reset[1]),
        .acc_mem_operation(acc_op[1]), .acc_addr(acc_addr[1]), .acc_wdata(acc_wdata[1]),
        .acc_rdata(acc_rdata[1]), .acc_opdone(acc_opdone[1]),
        .host_req(host_req[1]), .host_we(host_we[1]), .host_addr(host_addr[1]),
        .host_wdata(host_wdata[1]), .host_rdata(host_rdata[1]), .host_ack(host_ack[1]),
        .err(err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int ws(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input int d);
        check("rst_acc_rdata", acc_rdata[d], 32'h0);
        check("rst_host_rdata", host_rdata[d], 32'h0);
        check("rst_acc_opdone", 32'(acc_opdone[d]), 32'h0);
        check("rst_host_ack", 32'(host_ack[d]), 32'h0);
        check("rst_err", 32'(err[d]), 32'h0);
    endtask

    // One isolated transaction starting from IDLE; checks latency, pulse
    // width and read-data hold. Returns the read data seen at done.
    task automatic do_op(input int d, input bit host, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd);
        int lat;
        bit got;
        if (host) begin
            host_req[d]   = 1'b1;
            host_we[d]    = we;
            host_addr[d]  = addr[7:0];
            host_wdata[d] = wd;
        end else begin
            acc_op[d]    = we ? 2'b11 : 2'b01;
            acc_addr[d]  = addr;
            acc_wdata[d] = wd;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            step();
            lat++;
            got = host ? host_ack[d] : acc_opdone[d];
        end
        host_req[d] = 1'b0;
        acc_op[d]   = 2'b00;
        check(host ? "host_latency" : "acc_latency", 32'(lat), 32'(ws(d) + 2));
        rd = host ? host_rdata[d] : acc_rdata[d];
        step();
        check("done_width", 32'(host ? host_ack[d] : acc_opdone[d]), 32'h0);
        check("rdata_hold", host ? host_rdata[d] : acc_rdata[d], rd);
    endtask

    // Applies one transaction on instance 0 and checks it against the model.
    task automatic model_op(input bit host, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd);
        logic [31:0] rd;
        bit          oor;
        oor = !host && (addr[31:8] != 24'h0);
        do_op(0, host, we, addr, wd, rd);
        if (oor) ref_err = 1'b1;
        if (we && !oor) begin
            ref_mem[addr[7:0]]   = wd;
            ref_valid[addr[7:0]] = 1'b1;
        end
        if (!we && oor) check("rand_oor_rdata", rd, 32'h0);
        else if (!we && ref_valid[addr[7:0]]) check("rand_rdata", rd, ref_mem[addr[7:0]]);
        check("rand_err", 32'(err[0]), 32'(ref_err));
    endtask

    initial begin
        logic [31:0] rd;
        int          idx, pulses, e_cnt, nv, hack;
        int          order[$];

        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; acc_op[d] = 2'b00; acc_addr[d] = '0; acc_wdata[d] = '0;
            host_req[d] = 1'b0; host_we[d] = 1'b0; host_addr[d] = '0; host_wdata[d] = '0;
        end
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0;
            ref_valid[i] = 1'b0;
        end
        ref_err = 1'b0;

        // Vector table: host preload, readbacks, engine write then host read.
        nv = 0;
        for (int i = 0; i < 4; i++) vecs[nv++] = '{1, 1, 32'(i), 32'd2, 32'h0, 0};
        for (int i = 0; i < 8; i++) vecs[nv++] = '{1, 1, 32'(i + 4), 32'(i + 1), 32'h0, 0};
        vecs[nv++] = '{1, 1, 32'hFF, 32'h55, 32'h0, 0};
        vecs[nv++] = '{1, 0, 32'd5, 32'h0, 32'd2, 1};
        vecs[nv++] = '{0, 1, 32'd12, 32'h13, 32'h0, 0};
        vecs[nv++] = '{1, 0, 32'd12, 32'h0, 32'h13, 1};
        vecs[nv++] = '{0, 0, 32'd11, 32'h0, 32'd8, 1};
        vecs[nv++] = '{0, 0, 32'hFF, 32'h0, 32'h55, 1};

        step(); step();
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        check_reset_vals(0);

        for (int i = 0; i < nv; i++) begin
            do_op(0, vecs[i].host, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            if (vecs[i].we) begin
                ref_mem[vecs[i].addr[7:0]]   = vecs[i].wdata;
                ref_valid[vecs[i].addr[7:0]] = 1'b1;
            end
            if (vecs[i].chk) check("vec_rdata", rd, vecs[i].exp_rd);
            check("vec_err", 32'(err[0]), 32'h0);
        end

        // Engine holds read op and steps the address on each done pulse.
        acc_op[0] = 2'b01; acc_addr[0] = 32'd0; idx = 0; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (acc_opdone[0]) begin
                check("eng_seq_rdata", acc_rdata[0], 32'd2);
                pulses++;
                idx++;
                if (idx < 4) acc_addr[0] = 32'(idx);
                else acc_op[0] = 2'b00;
            end
        end
        acc_op[0] = 2'b00;
        check("eng_seq_pulses", 32'(pulses), 32'd4);

        // Randomised single transactions against the model (addresses 16..254).
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            bit h;
            h = $urandom_range(0, 1) == 1;
            a = 32'($urandom_range(16, 254));
            if (!h && $urandom_range(0, 5) == 0) a = a | (32'h100 << $urandom_range(0, 23));
            model_op(h, $urandom_range(0, 1) == 1, a, $urandom);
        end

        // Contention after reset: ties resolve engine, host, engine.
        reset[0] = 1'b1; step(); reset[0] = 1'b0;
        ref_err = 1'b0;
        check_reset_vals(0);
        acc_op[0] = 2'b01; acc_addr[0] = 32'd4;
        host_req[0] = 1'b1; host_we[0] = 1'b0; host_addr[0] = 8'd6;
        e_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (acc_opdone[0]) begin
                order.push_back(1);
                e_cnt++;
                check("cont_acc_rdata", acc_rdata[0], ref_mem[(e_cnt == 1) ? 4 : 5]);
                if (e_cnt == 1) acc_addr[0] = 32'd5;
                else acc_op[0] = 2'b00;
            end
            if (host_ack[0]) begin
                order.push_back(2);
                check("cont_host_rdata", host_rdata[0], ref_mem[6]);
                host_req[0] = 1'b0;
            end
        end
        acc_op[0] = 2'b00; host_req[0] = 1'b0;
        check("cont_count", 32'(order.size()), 32'd3);
        if (order.size() == 3)
            check("cont_order", 32'(order[0] * 100 + order[1] * 10 + order[2]), 32'd121);

        // Out-of-range engine accesses.
        do_op(0, 0, 0, 32'h100, 32'h0, rd);
        check("oor_rdata", rd, 32'h0);
        check("oor_err", 32'(err[0]), 32'h1);
        do_op(0, 0, 1, 32'h1FF, 32'hDEAD_BEEF, rd);
        do_op(0, 1, 0, 32'hFF, 32'h0, rd);
        check("oor_no_write", rd, ref_mem[8'hFF]);
        check("oor_err_sticky", 32'(err[0]), 32'h1);

        // Reset mid-write on the three-wait-state instance.
        do_op(1, 1, 1, 32'd7, 32'h11, rd);
        do_op(1, 0, 0, 32'h100, 32'h0, rd);
        check("ws3_err", 32'(err[1]), 32'h1);
        do_op(1, 0, 0, 32'd7, 32'h0, rd);
        check("ws3_acc_rd", rd, 32'h11);
        do_op(1, 1, 0, 32'd7, 32'h0, rd);
        check("ws3_host_rd", rd, 32'h11);
        host_req[1] = 1'b1; host_we[1] = 1'b1; host_addr[1] = 8'd7; host_wdata[1] = 32'hAA;
        step();
        step();
        check("mid_no_ack", 32'(host_ack[1]), 32'h0);
        reset[1] = 1'b1;
        host_req[1] = 1'b0;
        step();
        check_reset_vals(1);
        reset[1] = 1'b0;
        hack = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (host_ack[1]) hack++;
        end
        check("mid_ack_count", 32'(hack), 32'h0);
        do_op(1, 1, 0, 32'd7, 32'h0, rd);
        check("mid_not_committed", rd, 32'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
